// File: rtl/memory_access_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: default widths, FSM encoding and helpers.
package memory_access_stage_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_REG_ADDR_WIDTH = 5;
    localparam int unsigned DEF_TIMEOUT        = 16;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } memState_t;

    // Word accesses only: the two low byte-address bits must be zero.
    function automatic logic isAligned(input logic [1:0] lowBits);
        return lowBits == 2'b00;
    endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// EX/MEM inputs, data-memory handshake and MEM/WB outputs of the MEM stage.
interface memory_access_stage_if
    import memory_access_stage_pkg::*;
#(
    parameter int unsigned DW  = DEF_DATA_WIDTH,
    parameter int unsigned RAW = DEF_REG_ADDR_WIDTH
);
    logic           exValid;
    logic           exMemRead;
    logic           exMemWrite;
    logic           exMemToReg;
    logic           exRegWrite;
    logic [RAW-1:0] exWriteReg;
    logic [DW-1:0]  exResult;
    logic [DW-1:0]  exStoreData;
    logic           stall;

    logic           memReq;
    logic           memWe;
    logic [DW-1:0]  memAddr;
    logic [DW-1:0]  memWdata;
    logic [DW-1:0]  memRdata;
    logic           memAck;

    logic           memToReg;
    logic [DW-1:0]  readData;
    logic [DW-1:0]  result;
    logic           regWrite;
    logic [RAW-1:0] writeReg;
    logic           alignErr;
    logic           busErr;

    // The MEM stage itself: consumes EX/MEM, masters the memory bus, produces MEM/WB.
    modport master (
        input  exValid, exMemRead, exMemWrite, exMemToReg, exRegWrite, exWriteReg,
        input  exResult, exStoreData, memRdata, memAck,
        output stall, memReq, memWe, memAddr, memWdata,
        output memToReg, readData, result, regWrite, writeReg, alignErr, busErr
    );

    // The surrounding pipeline and data memory.
    modport slave (
        output exValid, exMemRead, exMemWrite, exMemToReg, exRegWrite, exWriteReg,
        output exResult, exStoreData, memRdata, memAck,
        input  stall, memReq, memWe, memAddr, memWdata,
        input  memToReg, readData, result, regWrite, writeReg, alignErr, busErr
    );

endinterface

// File: rtl/memory_access_stage_mem_wb_register.sv
// MEM/WB pipeline register: full load of a new bundle, or a bubble that only clears regWrite.
module mem_wb_register
    import memory_access_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic                      load,
    input  logic                      bubble,
    input  logic                      nxtMemToReg,
    input  logic [DATA_WIDTH-1:0]     nxtReadData,
    input  logic [DATA_WIDTH-1:0]     nxtResult,
    input  logic                      nxtRegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] nxtWriteReg,
    output logic                      memToReg,
    output logic [DATA_WIDTH-1:0]     readData,
    output logic [DATA_WIDTH-1:0]     result,
    output logic                      regWrite,
    output logic [REG_ADDR_WIDTH-1:0] writeReg
);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            memToReg <= 1'b0;
            readData <= '0;
            result   <= '0;
            regWrite <= 1'b0;
            writeReg <= '0;
        end else if (load) begin
            memToReg <= nxtMemToReg;
            readData <= nxtReadData;
            result   <= nxtResult;
            regWrite <= nxtRegWrite;
            writeReg <= nxtWriteReg;
        end else if (bubble) begin
            regWrite <= 1'b0;
        end
    end

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage: issues loads/stores over a req/ack handshake, stalls upstream while busy,
// flags misaligned accesses and timeouts, and feeds the MEM/WB register.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int unsigned TIMEOUT        = DEF_TIMEOUT
) (
    input logic                    clk,
    input logic                    rstN,
    memory_access_stage_if.master  bus
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT + 1);

    memState_t                 state, nextState;
    logic [CNT_WIDTH-1:0]      waitCnt, nextWaitCnt;
    logic                      stallC;
    logic                      startAccess;
    logic                      nextMemReq;
    logic                      nextAlignErr, nextBusErr;

    logic                      memReq, memWe;
    logic [DATA_WIDTH-1:0]     memAddr, memWdata;
    logic                      alignErr, busErr;

    logic                      holdIsLoad, holdMemToReg, holdRegWrite;
    logic [REG_ADDR_WIDTH-1:0] holdWriteReg;
    logic [DATA_WIDTH-1:0]     holdResult;

    logic                      wbLoad, wbBubble;
    logic                      wbMemToReg, wbRegWrite;
    logic [DATA_WIDTH-1:0]     wbReadData, wbResult;
    logic [REG_ADDR_WIDTH-1:0] wbWriteReg;

    logic                      memOp, aligned, timeoutHit;

    assign memOp      = bus.exValid & (bus.exMemRead | bus.exMemWrite);
    assign aligned    = isAligned(bus.exResult[1:0]);
    assign timeoutHit = (waitCnt == CNT_WIDTH'(TIMEOUT));

    // Next-state, stall and MEM/WB load selection.
    always_comb begin
        nextState    = state;
        nextWaitCnt  = waitCnt;
        nextMemReq   = memReq;
        nextAlignErr = 1'b0;
        nextBusErr   = 1'b0;
        stallC       = 1'b0;
        startAccess  = 1'b0;
        wbLoad       = 1'b0;
        wbBubble     = 1'b0;
        wbMemToReg   = bus.exMemToReg;
        wbReadData   = '0;
        wbResult     = bus.exResult;
        wbRegWrite   = bus.exRegWrite;
        wbWriteReg   = bus.exWriteReg;

        case (state)
            MEM_IDLE: begin
                if (!bus.exValid) begin
                    wbBubble = 1'b1;
                end else if (memOp && aligned) begin
                    stallC      = 1'b1;
                    startAccess = 1'b1;
                    wbBubble    = 1'b1;
                    nextMemReq  = 1'b1;
                    nextWaitCnt = CNT_WIDTH'(1);
                    nextState   = MEM_WAIT;
                end else if (memOp) begin
                    nextAlignErr = 1'b1;
                    wbLoad       = 1'b1;
                    wbRegWrite   = 1'b0;
                end else begin
                    wbLoad = 1'b1;
                end
            end
            MEM_WAIT: begin
                wbBubble = 1'b1;
                if (bus.memAck) begin
                    wbLoad      = 1'b1;
                    wbBubble    = 1'b0;
                    wbMemToReg  = holdMemToReg;
                    wbReadData  = holdIsLoad ? bus.memRdata : '0;
                    wbResult    = holdResult;
                    wbRegWrite  = holdRegWrite;
                    wbWriteReg  = holdWriteReg;
                    nextMemReq  = 1'b0;
                    nextWaitCnt = '0;
                    nextState   = MEM_IDLE;
                end else if (timeoutHit) begin
                    // The abandoned instruction retires as a bubble so upstream advances.
                    nextBusErr  = 1'b1;
                    nextMemReq  = 1'b0;
                    nextWaitCnt = '0;
                    nextState   = MEM_IDLE;
                end else begin
                    stallC      = 1'b1;
                    nextWaitCnt = waitCnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                nextState = MEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= MEM_IDLE;
            waitCnt  <= '0;
            memReq   <= 1'b0;
            alignErr <= 1'b0;
            busErr   <= 1'b0;
        end else begin
            state    <= nextState;
            waitCnt  <= nextWaitCnt;
            memReq   <= nextMemReq;
            alignErr <= nextAlignErr;
            busErr   <= nextBusErr;
        end
    end

    // Hold registers: the access and its bundle are frozen for the whole WAIT.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            memWe        <= 1'b0;
            memAddr      <= '0;
            memWdata     <= '0;
            holdIsLoad   <= 1'b0;
            holdMemToReg <= 1'b0;
            holdRegWrite <= 1'b0;
            holdWriteReg <= '0;
            holdResult   <= '0;
        end else if (startAccess) begin
            memWe        <= bus.exMemWrite & ~bus.exMemRead;
            memAddr      <= {bus.exResult[DATA_WIDTH-1:2], 2'b00};
            memWdata     <= bus.exStoreData;
            holdIsLoad   <= bus.exMemRead;
            holdMemToReg <= bus.exMemToReg;
            holdRegWrite <= bus.exRegWrite;
            holdWriteReg <= bus.exWriteReg;
            holdResult   <= bus.exResult;
        end
    end

    logic                      wbMemToRegQ, wbRegWriteQ;
    logic [DATA_WIDTH-1:0]     wbReadDataQ, wbResultQ;
    logic [REG_ADDR_WIDTH-1:0] wbWriteRegQ;

    mem_wb_register #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_memWb (
        .clk        (clk),
        .rstN       (rstN),
        .load       (wbLoad),
        .bubble     (wbBubble),
        .nxtMemToReg(wbMemToReg),
        .nxtReadData(wbReadData),
        .nxtResult  (wbResult),
        .nxtRegWrite(wbRegWrite),
        .nxtWriteReg(wbWriteReg),
        .memToReg   (wbMemToRegQ),
        .readData   (wbReadDataQ),
        .result     (wbResultQ),
        .regWrite   (wbRegWriteQ),
        .writeReg   (wbWriteRegQ)
    );

    // Stall is masked while reset is held so nothing toggles upstream.
    assign bus.stall    = rstN & stallC;
    assign bus.memReq   = memReq;
    assign bus.memWe    = memWe;
    assign bus.memAddr  = memAddr;
    assign bus.memWdata = memWdata;
    assign bus.memToReg = wbMemToRegQ;
    assign bus.readData = wbReadDataQ;
    assign bus.result   = wbResultQ;
    assign bus.regWrite = wbRegWriteQ;
    assign bus.writeReg = wbWriteRegQ;
    assign bus.alignErr = alignErr;
    assign bus.busErr   = busErr;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: transaction-level model checked every cycle plus directed literals.
module tb_memory_access_stage;

    localparam int unsigned DW  = 32;
    localparam int unsigned RAW = 5;
    localparam int unsigned TMO = 16;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    memory_access_stage_if #(.DW(DW), .RAW(RAW)) ifc ();

    memory_access_stage #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .TIMEOUT(TMO)
    ) dut (
        .clk (clk),
        .rstN(rstN),
        .bus (ifc.master)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: at most one outstanding access, retired by ack or by running out of patience.
    logic           pendValid = 0, pendLoad = 0, pendMemToReg = 0, pendRegWrite = 0;
    logic [RAW-1:0] pendWriteReg = 0;
    logic [DW-1:0]  pendResult = 0;
    int             pendAge = 0;
    logic           eMemReq = 0, eMemWe = 0, eMemToReg = 0, eRegWrite = 0, eAlign = 0, eBus = 0;
    logic [DW-1:0]  eMemAddr = 0, eMemWdata = 0, eReadData = 0, eResult = 0;
    logic [RAW-1:0] eWriteReg = 0;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pendValid <= 0; pendAge <= 0; pendLoad <= 0;
            eMemReq <= 0; eMemWe <= 0; eMemAddr <= 0; eMemWdata <= 0;
            eMemToReg <= 0; eReadData <= 0; eResult <= 0; eRegWrite <= 0; eWriteReg <= 0;
            eAlign <= 0; eBus <= 0;
        end else begin
            eAlign <= 0;
            eBus   <= 0;
            if (pendValid) begin
                if (ifc.memAck) begin
                    pendValid <= 0;
                    eMemReq   <= 0;
                    eMemToReg <= pendMemToReg;
                    eReadData <= pendLoad ? ifc.memRdata : 0;
                    eResult   <= pendResult;
                    eRegWrite <= pendRegWrite;
                    eWriteReg <= pendWriteReg;
                end else if (pendAge == TMO) begin
                    pendValid <= 0;
                    eMemReq   <= 0;
                    eBus      <= 1;
                    eRegWrite <= 0;
                end else begin
                    pendAge   <= pendAge + 1;
                    eRegWrite <= 0;
                end
            end else if (ifc.exValid) begin
                if ((ifc.exMemRead || ifc.exMemWrite) && (ifc.exResult % 4 == 0)) begin
                    pendValid    <= 1;
                    pendAge      <= 1;
                    pendLoad     <= ifc.exMemRead;
                    pendMemToReg <= ifc.exMemToReg;
                    pendRegWrite <= ifc.exRegWrite;
                    pendWriteReg <= ifc.exWriteReg;
                    pendResult   <= ifc.exResult;
                    eMemReq      <= 1;
                    eMemWe       <= ifc.exMemWrite && !ifc.exMemRead;
                    eMemAddr     <= (ifc.exResult / 4) * 4;
                    eMemWdata    <= ifc.exStoreData;
                    eRegWrite    <= 0;
                end else begin
                    eAlign    <= ifc.exMemRead || ifc.exMemWrite;
                    eMemToReg <= ifc.exMemToReg;
                    eReadData <= 0;
                    eResult   <= ifc.exResult;
                    eRegWrite <= ifc.exRegWrite && !(ifc.exMemRead || ifc.exMemWrite);
                    eWriteReg <= ifc.exWriteReg;
                end
            end else begin
                eRegWrite <= 0;
            end
        end
    end

    function automatic logic expStall();
        if (!rstN) return 1'b0;
        if (pendValid) return !(ifc.memAck || pendAge == TMO);
        return ifc.exValid && (ifc.exMemRead || ifc.exMemWrite) && (ifc.exResult % 4 == 0);
    endfunction

    always @(negedge clk) begin
        chk("stall",    DW'(ifc.stall),    DW'(expStall()));
        chk("memReq",   DW'(ifc.memReq),   DW'(eMemReq));
        if (eMemReq) begin
            chk("memWe",    DW'(ifc.memWe), DW'(eMemWe));
            chk("memAddr",  ifc.memAddr,    eMemAddr);
            chk("memWdata", ifc.memWdata,   eMemWdata);
        end
        chk("memToReg", DW'(ifc.memToReg), DW'(eMemToReg));
        chk("readData", ifc.readData,      eReadData);
        chk("result",   ifc.result,        eResult);
        chk("regWrite", DW'(ifc.regWrite), DW'(eRegWrite));
        chk("writeReg", DW'(ifc.writeReg), DW'(eWriteReg));
        chk("alignErr", DW'(ifc.alignErr), DW'(eAlign));
        chk("busErr",   DW'(ifc.busErr),   DW'(eBus));
    end

    task automatic drive(input logic v, input logic rd, input logic wr, input logic m2r,
                         input logic rw, input logic [RAW-1:0] wreg,
                         input logic [DW-1:0] res, input logic [DW-1:0] sd);
        ifc.exValid = v; ifc.exMemRead = rd; ifc.exMemWrite = wr; ifc.exMemToReg = m2r;
        ifc.exRegWrite = rw; ifc.exWriteReg = wreg; ifc.exResult = res; ifc.exStoreData = sd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks in the ackAt-th WAIT cycle (0 = never); upstream leaves when stall is low.
    task automatic runAccess(input int ackAt, input logic [DW-1:0] rdata,
                             output int stallCyc, output int reqCyc, output logic sWe,
                             output logic [DW-1:0] sAddr, output logic [DW-1:0] sWdata);
        int   seen;
        logic st;
        logic done;
        seen = 0; stallCyc = 0; reqCyc = 0; done = 0; sWe = 0; sAddr = 0; sWdata = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            st = ifc.stall;
            if (st) stallCyc++;
            if (ifc.memReq) begin
                reqCyc++;
                sWe = ifc.memWe; sAddr = ifc.memAddr; sWdata = ifc.memWdata;
            end
            @(posedge clk);
            #1;
            ifc.memAck = 0;
            ifc.memRdata = '0;
            if (!st) begin
                done = 1;
            end else if (ifc.memReq) begin
                seen++;
                if (seen == ackAt) begin
                    ifc.memAck = 1;
                    ifc.memRdata = rdata;
                end
            end
        end
        idle();
        chk("access_done", DW'(done), DW'(1));
    endtask

    int            sc, rc;
    logic          we;
    logic [DW-1:0] addr, wdata;

    initial begin
        idle();
        ifc.memAck = 0;
        ifc.memRdata = '0;

        // Reset held with inputs toggling.
        for (int i = 0; i < 4; i++) begin
            drive(1, i[0], ~i[0], 1, 1, RAW'(i + 1), DW'(32'h40 + 4 * i), DW'(i));
            ifc.memAck = i[1];
            step();
        end
        chk("rst_stall",    DW'(ifc.stall),    0);
        chk("rst_memReq",   DW'(ifc.memReq),   0);
        chk("rst_regWrite", DW'(ifc.regWrite), 0);
        idle();
        ifc.memAck = 0;
        @(posedge clk);
        #3 rstN = 1;
        step();

        // ALU op.
        drive(1, 0, 0, 0, 1, 5'd3, 32'd200, 32'd0);
        #1 chk("alu_stall", DW'(ifc.stall), 0);
        step();
        chk("alu_result",   ifc.result,        32'd200);
        chk("alu_regWrite", DW'(ifc.regWrite), 1);
        chk("alu_writeReg", DW'(ifc.writeReg), 3);
        idle();
        step();

        // Load 0x40 acked in the 4th WAIT cycle.
        drive(1, 1, 0, 1, 1, 5'd7, 32'h40, 32'd0);
        runAccess(4, 32'd100, sc, rc, we, addr, wdata);
        chk("ld_stallCycles", DW'(sc), 4);
        chk("ld_reqCycles",   DW'(rc), 4);
        chk("ld_addr",        addr,    32'h40);
        chk("ld_readData",    ifc.readData,      32'd100);
        chk("ld_memToReg",    DW'(ifc.memToReg), 1);
        chk("ld_regWrite",    DW'(ifc.regWrite), 1);
        step();

        // Store 0x44 acked in the 2nd WAIT cycle.
        drive(1, 0, 1, 0, 0, 5'd0, 32'h44, 32'h5A);
        runAccess(2, 32'hDEAD, sc, rc, we, addr, wdata);
        chk("st_memWe",    DW'(we), 1);
        chk("st_memAddr",  addr,    32'h44);
        chk("st_memWdata", wdata,   32'h5A);
        chk("st_regWrite", DW'(ifc.regWrite), 0);
        chk("st_readData", ifc.readData,      0);

        // Ack while idle must be ignored.
        ifc.memAck = 1;
        ifc.memRdata = 32'h1234;
        step();
        ifc.memAck = 0;
        ifc.memRdata = '0;

        // Misaligned load.
        drive(1, 1, 0, 1, 1, 5'd9, 32'h42, 32'd0);
        #1 chk("mis_stall", DW'(ifc.stall), 0);
        step();
        chk("mis_alignErr", DW'(ifc.alignErr), 1);
        chk("mis_memReq",   DW'(ifc.memReq),   0);
        chk("mis_regWrite", DW'(ifc.regWrite), 0);
        idle();
        step();
        chk("mis_alignPulse", DW'(ifc.alignErr), 0);

        // Load with no ack: timeout, then the next instruction proceeds.
        drive(1, 1, 0, 1, 1, 5'd4, 32'h80, 32'd0);
        runAccess(0, 32'd0, sc, rc, we, addr, wdata);
        chk("to_reqCycles", DW'(rc), TMO);
        chk("to_busErr",    DW'(ifc.busErr),   1);
        chk("to_memReq",    DW'(ifc.memReq),   0);
        chk("to_regWrite",  DW'(ifc.regWrite), 0);
        drive(1, 0, 0, 0, 1, 5'd6, 32'd77, 32'd0);
        step();
        chk("to_busPulse", DW'(ifc.busErr),   0);
        chk("to_next",     ifc.result,        32'd77);
        idle();
        step();

        // Ack in the last allowed cycle wins over the timeout.
        drive(1, 1, 0, 1, 1, 5'd8, 32'h90, 32'd0);
        runAccess(TMO, 32'hCAFE, sc, rc, we, addr, wdata);
        chk("ack16_busErr",   DW'(ifc.busErr), 0);
        chk("ack16_readData", ifc.readData,    32'hCAFE);
        step();

        // Reset asserted mid-WAIT drops the request at once.
        drive(1, 1, 0, 1, 1, 5'd2, 32'hA0, 32'd0);
        step();
        chk("mw_memReqUp", DW'(ifc.memReq), 1);
        #2 rstN = 0;
        idle();
        #1;
        chk("mw_memReq", DW'(ifc.memReq), 0);
        chk("mw_stall",  DW'(ifc.stall),  0);
        step();
        #2 rstN = 1;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
